// File: rtl/uart_tx_ctrl_if.sv
// Requester-side bus for the UART transmit controller: CPU write port plus debug byte stream.
interface uart_tx_ctrl_if;
  logic        wr_valid;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        dbg_valid;
  logic [7:0]  dbg_data;
  logic        dbg_ready;

  modport master (
    output wr_valid, wr_addr, wr_data, dbg_valid, dbg_data,
    input  wr_ready, dbg_ready
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, dbg_valid, dbg_data,
    output wr_ready, dbg_ready
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: round-robin CPU/debug byte intake, byte FIFO, and a
// drain FSM that launches one byte at a time into the tx core.
module uart_tx_ctrl #(
  parameter int LOGD    = 7,
  parameter int FIFO_AW = 3
) (
  input  logic             clk,
  input  logic             i_reset_n,
  uart_tx_ctrl_if.slave    bus,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic [FIFO_AW:0] fifo_level,
  output logic             tx_active
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, ARM, WAIT} state_t;
  typedef enum logic {GNT_CPU, GNT_DBG} grant_t;

  state_t             state;
  grant_t             last_grant;
  logic               dbg_en;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;

  logic       uart_sel;
  logic       data_wr;
  logic       ctrl_wr;
  logic       flush;
  logic       full;
  logic       empty;
  logic       cpu_elig;
  logic       dbg_elig;
  logic       grant_cpu;
  logic       grant_dbg;
  logic       push;
  logic       pop;
  logic [7:0] push_data;
  logic       unused_bus_bits;

  assign uart_sel = bus.wr_valid && bus.wr_addr[LOGD];
  assign data_wr  = uart_sel && !bus.wr_addr[2];
  assign ctrl_wr  = uart_sel && bus.wr_addr[2];
  assign flush    = ctrl_wr && bus.wr_data[0];

  assign full  = (fifo_level == FULL_LVL);
  assign empty = (fifo_level == '0);

  // A data write and a control write never share a cycle, so excluding debug
  // from control cycles is enough to make flush win over any push.
  assign cpu_elig  = data_wr && !full;
  assign dbg_elig  = bus.dbg_valid && dbg_en && !full && !ctrl_wr;
  assign grant_cpu = cpu_elig && (!dbg_elig || last_grant == GNT_DBG);
  assign grant_dbg = dbg_elig && (!cpu_elig || last_grant == GNT_CPU);

  assign push      = grant_cpu || grant_dbg;
  assign push_data = grant_cpu ? bus.wr_data[7:0] : bus.dbg_data;
  assign pop       = (state == IDLE) && !empty;

  assign bus.wr_ready  = grant_cpu || ctrl_wr || (bus.wr_valid && !bus.wr_addr[LOGD]);
  assign bus.dbg_ready = grant_dbg;

  assign unused_bus_bits = ^{bus.wr_addr, bus.wr_data[31:8]};

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      dbg_en     <= 1'b0;
      last_grant <= GNT_DBG;
    end else begin
      if (ctrl_wr) dbg_en <= bus.wr_data[1];
      if (grant_cpu) last_grant <= GNT_CPU;
      else if (grant_dbg) last_grant <= GNT_DBG;

      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_level <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        fifo_level <= fifo_level + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // ARM exists because the tx core raises tx_busy a cycle after tx_start.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      tx_active <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            tx_data   <= mem[rd_ptr];
            tx_start  <= 1'b1;
            tx_active <= 1'b1;
            state     <= START;
          end
        end
        START: state <= ARM;
        ARM:   state <= WAIT;
        WAIT: begin
          if (!tx_busy) begin
            tx_active <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          tx_active <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule
